// File: rtl/user_wb_bridge.sv
// Wishbone classic bridge: one upstream slave port decoded onto NCH downstream channel windows.
// Define USER_WB_BRIDGE_STATUS_EN to add the timeout/miss status register at channel index 8'hFF.
module user_wb_bridge #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned AW_CH    = 16,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] BASE     = 32'h3000_0000,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [NCH-1:0]    m_cyc_o,
  output logic [NCH-1:0]    m_stb_o,
  output logic              m_we_o,
  output logic [3:0]        m_sel_o,
  output logic [31:0]       m_adr_o,
  output logic [31:0]       m_dat_o,
  input  logic [NCH*32-1:0] m_dat_i,
  input  logic [NCH-1:0]    m_ack_i
);

  localparam int unsigned CMP_LSB = AW_CH + 8;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [2:0]  ch_q, ch_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic [15:0] cnt_q, cnt_d;

  logic [7:0]  idx;
  logic        base_hit, ch_hit, req;
  logic        sel_ack;
  logic [31:0] sel_dat;

  assign idx      = wbs_adr_i[AW_CH+7:AW_CH];
  assign base_hit = (wbs_adr_i[31:CMP_LSB] == BASE[31:CMP_LSB]);
  assign ch_hit   = base_hit && (32'(idx) < NCH);
  // The ack is registered, so the master still drives stb during the ack cycle; don't re-accept it.
  assign req      = wbs_cyc_i && wbs_stb_i && !ack_q;

`ifdef USER_WB_BRIDGE_STATUS_EN
  logic        stat_hit;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;

  assign stat_hit = base_hit && (idx == 8'hFF);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int n = 0; n < NCH; n++) begin
      if (ch_q == 3'(n)) begin
        sel_ack = m_ack_i[n];
        sel_dat = m_dat_i[n*32 +: 32];
      end
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    ch_d    = ch_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    cnt_d   = cnt_q;
`ifdef USER_WB_BRIDGE_STATUS_EN
    miss_cnt_d = miss_cnt_q;
    to_cnt_d   = to_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d  = wbs_we_i;
          sel_d = wbs_sel_i;
          adr_d = wbs_adr_i;
          dat_d = wbs_dat_i;
          ch_d  = idx[2:0];
          cnt_d = '0;
          if (ch_hit) begin
            state_d = ACCESS;
          end
`ifdef USER_WB_BRIDGE_STATUS_EN
          else if (stat_hit) begin
            rdata_d = {to_cnt_q, miss_cnt_q};
            state_d = RESP;
            if (wbs_we_i) begin
              miss_cnt_d = '0;
              to_cnt_d   = '0;
            end
          end
`endif
          else begin
            rdata_d = ERR_DATA;
            state_d = RESP;
`ifdef USER_WB_BRIDGE_STATUS_EN
            miss_cnt_d = sat_inc(miss_cnt_q);
`endif
          end
        end
      end

      ACCESS: begin
        // Abort beats ack: an abandoned cycle must never produce an upstream ack.
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (sel_ack) begin
          rdata_d = sel_dat;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = ERR_DATA;
          state_d = RESP;
`ifdef USER_WB_BRIDGE_STATUS_EN
          to_cnt_d = sat_inc(to_cnt_q);
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      RESP: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the async reset clears every register, outputs included; there is no memory array here.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      ch_q    <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of the others.
      state_q <= state_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      ch_q    <= ch_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef USER_WB_BRIDGE_STATUS_EN
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      miss_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end
`endif

  always_comb begin
    m_stb_o = '0;
    for (int n = 0; n < NCH; n++) begin
      m_stb_o[n] = (state_q == ACCESS) && (ch_q == 3'(n));
    end
  end

  assign m_cyc_o   = m_stb_o;
  assign m_we_o    = we_q;
  assign m_sel_o   = sel_q;
  assign m_adr_o   = adr_q;
  assign m_dat_o   = dat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdata_q;

endmodule

// File: tb/tb_user_wb_bridge.sv
// Self-checking bench for user_wb_bridge: directed table, abort/reset sequences and random traffic
// against a transaction-level reference model.
module tb_user_wb_bridge;

  localparam int          NCH     = 4;
  localparam int          AW_CH   = 16;
  localparam int          TIMEOUT = 10;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cyc, stb, we;
  logic [3:0]        sel;
  logic [31:0]       adr, dat;
  logic              wbs_ack;
  logic [31:0]       wbs_dat;
  logic [NCH-1:0]    m_cyc, m_stb;
  logic              m_we;
  logic [3:0]        m_sel;
  logic [31:0]       m_adr, m_dat;
  logic [NCH*32-1:0] m_dat_i;
  logic [NCH-1:0]    m_ack_i;

  always #5 clk = ~clk;

  user_wb_bridge #(
    .NCH(NCH), .AW_CH(AW_CH), .TIMEOUT(TIMEOUT), .BASE(BASE), .ERR_DATA(ERR)
  ) dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(wbs_ack), .wbs_dat_o(wbs_dat),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
    .m_adr_o(m_adr), .m_dat_o(m_dat), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Downstream slaves: ack on strobe cycle number ack_delay (0 = first), -1 never acks.
  int          ack_delay[NCH];
  logic [31:0] slv_data[NCH];
  int          stb_age[NCH];

  always @(negedge clk) begin
    for (int n = 0; n < NCH; n++) begin
      if (m_stb[n]) begin
        m_ack_i[n] = (ack_delay[n] >= 0) && (stb_age[n] == ack_delay[n]);
        m_dat_i[n*32 +: 32] = slv_data[n];
        stb_age[n]++;
      end else begin
        m_ack_i[n] = 1'b0;
        stb_age[n] = 0;
      end
    end
  end

  // Reference model: whole-transaction outcome from the address map and slave behaviour.
  int mdl_miss = 0;
  int mdl_to   = 0;

  task automatic model(input logic [31:0] a, input logic w, input int dly, input logic [31:0] sd,
                       output logic [NCH-1:0] e_mask, output int e_lat,
                       output logic [31:0] e_dat, output int e_stb);
    bit base_ok;
    int idx;
    base_ok = (a[31:24] == BASE[31:24]);
    idx     = int'(a[23:16]);
    e_mask  = '0;
    e_stb   = 0;
    e_lat   = 2;
    e_dat   = ERR;
    if (base_ok && idx < NCH) begin
      e_mask[idx] = 1'b1;
      if (dly >= 0 && dly < TIMEOUT) begin
        e_lat = dly + 3;
        e_dat = sd;
        e_stb = dly + 1;
      end else begin
        e_lat  = TIMEOUT + 2;
        e_stb  = TIMEOUT;
        mdl_to = (mdl_to < 65535) ? mdl_to + 1 : mdl_to;
      end
    end
`ifdef USER_WB_BRIDGE_STATUS_EN
    else if (base_ok && idx == 255) begin
      e_dat = {mdl_to[15:0], mdl_miss[15:0]};
      if (w) begin
        mdl_to   = 0;
        mdl_miss = 0;
      end
    end
`endif
    else begin
      mdl_miss = (mdl_miss < 65535) ? mdl_miss + 1 : mdl_miss;
    end
  endtask

  // One upstream transaction; starts and ends just after a falling edge.
  task automatic run_txn(input string tag, input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, input int dly, input logic [31:0] sd,
                         input logic [NCH-1:0] e_mask, input int e_lat, input logic [31:0] e_dat,
                         input bit chk_dat, input int e_stb);
    logic [NCH-1:0] mask_seen;
    logic [31:0]    got_dat;
    int             stb_cnt, lat;
    bit             req_ok, first, onehot_ok;
    mask_seen = '0; got_dat = '0; stb_cnt = 0; lat = 0;
    req_ok = 1'b1; first = 1'b1; onehot_ok = 1'b1;
    for (int n = 0; n < NCH; n++) begin
      ack_delay[n] = dly;
      slv_data[n]  = sd;
    end
    adr = a; we = w; sel = s; dat = d; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(negedge clk);
      mask_seen |= m_stb;
      if (m_stb != '0) stb_cnt++;
      if ($countones(m_stb) > 1 || m_cyc !== m_stb) onehot_ok = 1'b0;
      if (m_stb != '0 && first) begin
        first = 1'b0;
        if ({m_we, m_sel, m_adr, m_dat} !== {w, s, a, d}) req_ok = 1'b0;
      end
      if (wbs_ack === 1'b1) begin
        lat     = k;
        got_dat = wbs_dat;
      end
    end
    check({tag, " latency"}, lat, e_lat);
    check({tag, " strobe mask"}, mask_seen, e_mask);
    check({tag, " strobe cycles"}, stb_cnt, e_stb);
    check({tag, " one-hot strobes"}, onehot_ok, 1);
    if (e_mask != '0) check({tag, " downstream request"}, req_ok, 1);
    if (chk_dat) check({tag, " read data"}, got_dat, e_dat);
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check({tag, " ack width"}, wbs_ack, 0);
  endtask

  task automatic mtxn(input string tag, input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d, input int dly, input logic [31:0] sd);
    logic [NCH-1:0] e_mask;
    int             e_lat, e_stb;
    logic [31:0]    e_dat;
    model(a, w, dly, sd, e_mask, e_lat, e_dat, e_stb);
    run_txn(tag, a, w, s, d, dly, sd, e_mask, e_lat, e_dat, !w, e_stb);
  endtask

  typedef struct {
    logic [31:0]    adr;
    logic           we;
    logic [3:0]     sel;
    logic [31:0]    wdat;
    int             dly;
    logic [31:0]    sdat;
    logic [NCH-1:0] e_mask;
    int             e_lat;
    logic [31:0]    e_dat;
    bit             chk;
    int             e_stb;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int   dly_pool[7];
    logic [31:0] last_dat;
    bit   ack_seen;

    dly_pool = '{0, 1, 2, 5, 9, 10, -1};
    vecs.push_back('{32'h3001_0010, 1'b0, 4'hF,    32'h0,         0, 32'h1234_5678, 4'b0010,  3, 32'h1234_5678, 1'b1,  1});
    vecs.push_back('{32'h3003_0000, 1'b1, 4'b0011, 32'hA5A5_A5A5, 0, 32'h0,         4'b1000,  3, 32'h0,         1'b0,  1});
    vecs.push_back('{32'h3005_0000, 1'b0, 4'hF,    32'h0,         0, 32'h1111_1111, 4'b0000,  2, ERR,           1'b1,  0});
    vecs.push_back('{32'h3000_0004, 1'b0, 4'hF,    32'h0,        -1, 32'h2222_2222, 4'b0001, 12, ERR,           1'b1, 10});
    vecs.push_back('{32'h3002_0000, 1'b0, 4'hF,    32'h0,         9, 32'hCAFE_0009, 4'b0100, 12, 32'hCAFE_0009, 1'b1, 10});
    vecs.push_back('{32'h3000_0000, 1'b0, 4'hF,    32'h0,         3, 32'h0BAD_F00D, 4'b0001,  6, 32'h0BAD_F00D, 1'b1,  4});
    vecs.push_back('{32'h3101_0000, 1'b0, 4'hF,    32'h0,         0, 32'h3333_3333, 4'b0000,  2, ERR,           1'b1,  0});
    vecs.push_back('{32'h3004_0000, 1'b0, 4'hF,    32'h0,         0, 32'h4444_4444, 4'b0000,  2, ERR,           1'b1,  0});
`ifndef USER_WB_BRIDGE_STATUS_EN
    vecs.push_back('{32'h30FF_0000, 1'b0, 4'hF,    32'h0,         0, 32'h5555_5555, 4'b0000,  2, ERR,           1'b1,  0});
`endif
    vecs.push_back('{32'h3003_FFFC, 1'b0, 4'hF,    32'h0,         1, 32'h7777_0003, 4'b1000,  4, 32'h7777_0003, 1'b1,  2});

    for (int n = 0; n < NCH; n++) begin
      ack_delay[n] = -1;
      slv_data[n]  = '0;
      stb_age[n]   = 0;
    end
    m_ack_i = '0;
    m_dat_i = '0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0000; dat = 32'h0;

    // Reset state, with a request already pending on the bus.
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset wbs_ack_o", wbs_ack, 0);
    check("reset wbs_dat_o", wbs_dat, 0);
    check("reset m_stb_o", m_stb, 0);
    check("reset m_cyc_o", m_cyc, 0);
    check("reset m_adr_o", m_adr, 0);
    check("reset m_we/sel", {m_we, m_sel}, 0);
    check("reset m_dat_o", m_dat, 0);
    rstn = 1'b1;
    #1 check("no accept before first edge out of reset", m_stb, 0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].wdat,
              vecs[i].dly, vecs[i].sdat, vecs[i].e_mask, vecs[i].e_lat, vecs[i].e_dat,
              vecs[i].chk, vecs[i].e_stb);
    last_dat = vecs[vecs.size()-1].e_dat;

    // Upstream abandons the cycle during ACCESS.
    for (int n = 0; n < NCH; n++) ack_delay[n] = -1;
    adr = 32'h3002_0000; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("abort strobe raised", m_stb, 4'b0100);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("abort strobe dropped", m_stb, 0);
    ack_seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (wbs_ack === 1'b1) ack_seen = 1'b1;
    end
    check("abort no ack", ack_seen, 0);
    check("abort wbs_dat_o held", wbs_dat, last_dat);
    run_txn("after abort", 32'h3002_0008, 1'b0, 4'hF, 32'h0, 0, 32'h600D_0002,
            4'b0100, 3, 32'h600D_0002, 1'b1, 1);

    // Reset asserted mid-ACCESS clears outputs without a clock edge.
    adr = 32'h3001_0000; we = 1'b1; sel = 4'h5; dat = 32'h1357_9BDF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("pre-reset strobe", m_stb, 4'b0010);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async reset m_stb_o", m_stb, 0);
    check("async reset m_cyc_o", m_cyc, 0);
    check("async reset wbs_ack_o", wbs_ack, 0);
    check("async reset wbs_dat_o", wbs_dat, 0);
    check("async reset m_adr_o", m_adr, 0);
    check("async reset m_dat_o", m_dat, 0);
    check("async reset m_we/sel", {m_we, m_sel}, 0);
    cyc = 1'b0; stb = 1'b0;
    mdl_miss = 0;
    mdl_to   = 0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_txn("after reset", 32'h3001_0000, 1'b0, 4'hF, 32'h0, 0, 32'hFEED_0001,
            4'b0010, 3, 32'hFEED_0001, 1'b1, 1);

`ifdef USER_WB_BRIDGE_STATUS_EN
    mtxn("stat clear", 32'h30FF_0000, 1'b1, 4'hF, 32'h0, 0, 32'h0);
    mtxn("stat miss0", 32'h3005_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0);
    mtxn("stat miss1", 32'h3100_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0);
    mtxn("stat tmo",   32'h3001_0000, 1'b0, 4'hF, 32'h0, -1, 32'h0);
    run_txn("stat read", 32'h30FF_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0,
            4'b0000, 2, 32'h0001_0002, 1'b1, 0);
    mtxn("stat wclr", 32'h30FF_0000, 1'b1, 4'hF, 32'h0, 0, 32'h0);
    run_txn("stat read cleared", 32'h30FF_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0,
            4'b0000, 2, 32'h0, 1'b1, 0);
`endif

    // Random traffic against the model.
    for (int t = 0; t < 40; t++) begin
      logic [7:0]  r_base, r_idx;
      logic [31:0] r_adr;
      int          r;
      r      = int'($urandom_range(0, 9));
      r_idx  = (r < 6) ? 8'(r) : ((r < 8) ? 8'hFF : 8'($urandom));
      r_base = ($urandom_range(0, 4) == 0) ? 8'($urandom) : BASE[31:24];
      r_adr  = {r_base, r_idx, 16'($urandom)};
      mtxn($sformatf("rand%0d", t), r_adr, 1'($urandom), 4'($urandom), $urandom,
           dly_pool[$urandom_range(0, 6)], $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
